// File: rtl/fb_pdm_sched.sv
// Binary-weighted PDM feedback scheduler: one-hot select per clock, code bit j picked 2^j times per frame.
// Optional FB_PDM_DITHER_EN: the c=0 idle slot outputs bit 0 of a per-frame 8-bit LFSR instead of 0.
module fb_pdm_sched #(
    parameter int NBITS = 10
) (
    input  logic             clk_ext,
    input  logic             rstb,
    input  logic             en,
    input  logic [NBITS-1:0] code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic [NBITS-1:0] sel,
    output logic             fb_out,
    output logic             frame_start,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam int         STAGES  = 1;
    localparam logic [NBITS-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [NBITS-1:0] sel;
        logic             fb;
        logic             fs;
    } out_t;

    logic [1:0]       state, state_nxt;
    logic [NBITS-1:0] cnt;
    logic [NBITS-1:0] code_active, code_pend;
    logic             pend_full;
    logic             running, wrap, xfer;
    logic [NBITS-1:0] low_bit, slot_sel;
    logic             idle_bit;
    logic [STAGES:0]  vld_pipe;
    out_t             out_q;

    assign running    = (state != ST_IDLE);
    assign wrap       = running && (cnt == CNT_MAX);
    assign xfer       = code_valid && !pend_full;
    assign code_ready = !pend_full;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_RUN;
            ST_RUN:  if (!en) state_nxt = ST_STOP;
            ST_STOP: begin
                if (en)        state_nxt = ST_RUN;
                else if (wrap) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= running ? cnt + 1'b1 : '0;
        end
    end

    // Active code only moves at the frame boundary; an offer on the wrap edge skips the pending slot.
    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            code_active <= '0;
            code_pend   <= '0;
            pend_full   <= 1'b0;
        end else if (!running) begin
            if (xfer) code_active <= code_in;
        end else if (wrap) begin
            if (xfer) begin
                code_active <= code_in;
            end else if (pend_full) begin
                code_active <= code_pend;
                pend_full   <= 1'b0;
            end
        end else if (xfer) begin
            code_pend <= code_in;
            pend_full <= 1'b1;
        end
    end

    // Slot = bit NBITS-1-tz(cnt): isolate the lowest set bit, then mirror it.
    assign low_bit = cnt & (-cnt);

    always_comb begin
        slot_sel = '0;
        for (int i = 0; i < NBITS; i++) slot_sel[NBITS-1-i] = low_bit[i];
    end

`ifdef FB_PDM_DITHER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb)     lfsr <= 8'h01;
        else if (wrap) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign idle_bit = lfsr[0];
`else
    assign idle_bit = 1'b0;
`endif

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            out_q <= '0;
        end else if (running) begin
            out_q.sel <= slot_sel;
            out_q.fb  <= (cnt == '0) ? idle_bit : |(slot_sel & code_active);
            out_q.fs  <= (cnt == '0);
        end else begin
            out_q <= '0;
        end
    end

    // busy rides the same one-stage pipe as the data outputs so it drops with them.
    assign vld_pipe[0] = running;

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) vld_pipe[STAGES:1] <= '0;
        else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign sel         = out_q.sel;
    assign fb_out      = out_q.fb;
    assign frame_start = out_q.fs;
    assign busy        = vld_pipe[STAGES];

endmodule

// File: tb/tb_fb_pdm_sched.sv
// Directed bench for fb_pdm_sched (default build, no dither): per-frame ones counts, slot order, handshake, stop/restart, reset.
module tb_fb_pdm_sched;

    localparam int NB    = 10;
    localparam int FRAME = 1 << NB;

    logic          clk_ext = 1'b0;
    logic          rstb = 1'b0;
    logic          en = 1'b0;
    logic [NB-1:0] code_in = '0;
    logic          code_valid = 1'b0;
    logic          code_ready;
    logic [NB-1:0] sel;
    logic          fb_out;
    logic          frame_start;
    logic          busy;

    fb_pdm_sched #(.NBITS(NB)) dut (
        .clk_ext(clk_ext), .rstb(rstb), .en(en), .code_in(code_in),
        .code_valid(code_valid), .code_ready(code_ready), .sel(sel),
        .fb_out(fb_out), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk_ext = ~clk_ext;

    typedef struct {
        logic [NB-1:0] code;
        int            exp_ones;
    } vec_t;

    vec_t vecs[3];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_ext);
        #1;
    endtask

    function automatic logic [NB-1:0] exp_sel(input int c);
        logic [NB-1:0] r;
        int k;
        r = '0;
        if (c != 0) begin
            k = 0;
            while (((c >> k) & 1) == 0) k++;
            r[NB-1-k] = 1'b1;
        end
        return r;
    endfunction

    // Walks one output frame starting at the displayed c=0 cycle; optional offer / en edges at given c.
    task automatic frame(input int offer_at, input logic [NB-1:0] offer_code,
                         input int drop_at, input int raise_at,
                         output int ones, output int bad, output int rdy_after);
        ones = 0; bad = 0; rdy_after = -1;
        for (int c = 0; c < FRAME; c++) begin
            if (sel !== exp_sel(c)) bad++;
            if (frame_start !== (c == 0)) bad++;
            if (busy !== 1'b1) bad++;
            if (fb_out === 1'b1) ones++;
            if (c == offer_at) begin code_in = offer_code; code_valid = 1'b1; end
            if (c == drop_at) en = 1'b0;
            if (c == raise_at) en = 1'b1;
            tick;
            if (c == offer_at) begin code_valid = 1'b0; rdy_after = int'(code_ready); end
        end
    endtask

    task automatic load_idle(input logic [NB-1:0] code);
        code_in = code; code_valid = 1'b1;
        tick;
        code_valid = 1'b0;
    endtask

    task automatic start_run;
        en = 1'b1;
        tick;
        tick;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        en = 1'b0;
        while (busy !== 1'b0 && cyc < 3 * FRAME) begin tick; cyc++; end
        check(name, int'(busy), 0);
    endtask

    initial begin
        int ones, bad, rdy, cyc;
        logic [NB-1:0] s1, s512;

        vecs[0] = '{10'd0,    0};
        vecs[1] = '{10'd1023, 1023};
        vecs[2] = '{10'h155,  341};

        tick; tick;
        check("reset_sel", int'(sel), 0);
        check("reset_busy_fb_fs", int'({busy, fb_out, frame_start}), 0);
        check("reset_ready", int'(code_ready), 1);
        rstb = 1'b1;
        tick;

        foreach (vecs[i]) begin
            load_idle(vecs[i].code);
            check("idle_load_ready", int'(code_ready), 1);
            start_run;
            for (int f = 0; f < 3; f++) begin
                frame(-1, '0, -1, -1, ones, bad, rdy);
                check($sformatf("ones_v%0d_f%0d", i, f), ones, vecs[i].exp_ones);
                check($sformatf("slot_v%0d_f%0d", i, f), bad, 0);
            end
            en = 1'b0;
            cyc = 0;
            while (busy !== 1'b0 && cyc < 3 * FRAME) begin tick; cyc++; end
            check("stop_latency", cyc, FRAME);
        end

        // Slot order with only bit 9 set: fb_out high exactly on odd c.
        load_idle(10'h200);
        start_run;
        bad = 0; s1 = '0; s512 = '0;
        for (int c = 0; c < FRAME; c++) begin
            if (fb_out !== ((c & 1) == 1)) bad++;
            if (c == 1) s1 = sel;
            if (c == 512) s512 = sel;
            tick;
        end
        check("odd_only", bad, 0);
        check("sel_c1", int'(s1), 'h200);
        check("sel_c512", int'(s512), 'h001);
        wait_idle("slot_stop");

        // Mid-frame update, then same-edge load on the wrap.
        load_idle(10'd5);
        start_run;
        frame(300, 10'd700, -1, -1, ones, bad, rdy);
        check("mid_ones_old", ones, 5);
        check("mid_ready_drop", rdy, 0);
        check("mid_slot", bad, 0);
        check("mid_ready_reassert", int'(code_ready), 1);
        frame(1022, 10'd170, -1, -1, ones, bad, rdy);
        check("mid_ones_new", ones, 700);
        check("same_edge_ready", rdy, 1);
        frame(-1, '0, -1, -1, ones, bad, rdy);
        check("same_edge_ones", ones, 170);
        check("same_edge_slot", bad, 0);
        wait_idle("mid_stop");

        // Stop at c=100: frame still completes, then idle.
        start_run;
        frame(-1, '0, 100, -1, ones, bad, rdy);
        check("stop_frame_ones", ones, 170);
        check("stop_frame_slot", bad, 0);
        check("stop_idle_busy_sel_fb", int'({busy, sel, fb_out}), 0);
        tick; tick;
        check("stop_stays_idle", int'({busy, frame_start, sel}), 0);

        // Drop at 100, re-raise at 900: next frame follows without a gap.
        start_run;
        frame(-1, '0, 100, 900, ones, bad, rdy);
        check("restart_ones0", ones, 170);
        check("restart_slot0", bad, 0);
        frame(-1, '0, -1, -1, ones, bad, rdy);
        check("restart_ones1", ones, 170);
        check("restart_slot1", bad, 0);
        wait_idle("restart_stop");

        // Reset mid-frame with a code pending.
        load_idle(10'd9);
        start_run;
        for (int c = 0; c < 417; c++) tick;
        code_in = 10'd33; code_valid = 1'b1;
        tick;
        code_valid = 1'b0;
        check("pend_full_pre_reset", int'(code_ready), 0);
        #2 rstb = 1'b0;
        #1;
        check("rst_mid_outs", int'({busy, fb_out, frame_start, sel}), 0);
        check("rst_mid_ready", int'(code_ready), 1);
        en = 1'b0;
        tick;
        rstb = 1'b1;
        tick;
        check("post_reset_idle", int'({busy, sel}), 0);
        start_run;
        frame(-1, '0, -1, -1, ones, bad, rdy);
        check("post_reset_ones", ones, 0);
        check("post_reset_slot", bad, 0);
        wait_idle("post_reset_stop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
